// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide controller.
// Holds FSM states, op-type encoding and the iteration count.
package hilo_muldiv_ctrl_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
        return (sgn && x[31]) ? -x : x;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage side of the HI/LO multiply/divide unit.
// master = pipeline issuing ops, slave = the controller.
interface hilo_muldiv_ctrl_if;

    logic        StartMult;
    logic        StartDiv;
    logic        SignedOp;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        MtHi;
    logic        MtLo;
    logic [31:0] MtData;
    logic        HiLoRead;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        Busy;
    logic        Stall;
    logic        Done;

    modport master (
        output StartMult, StartDiv, SignedOp, OpA, OpB,
        output MtHi, MtLo, MtData, HiLoRead,
        input  HiOut, LoOut, Busy, Stall, Done
    );

    modport slave (
        input  StartMult, StartDiv, SignedOp, OpA, OpB,
        input  MtHi, MtLo, MtData, HiLoRead,
        output HiOut, LoOut, Busy, Stall, Done
    );

endinterface

// File: rtl/muldiv_step.sv
// Radix-2 datapath: shift-add multiply and restoring divide on
// unsigned magnitudes; {hi,lo} is the shared working register.
module muldiv_step
    import hilo_muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  op_t         op,
    input  logic [31:0] lo_init,
    input  logic [31:0] m_init,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] m;
    logic [32:0] sum;
    logic [32:0] rem;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] nxt_hi;
    logic [31:0] nxt_lo;

    // hi stays below m during divide, so diff[32] is a clean borrow
    always_comb begin
        sum    = {1'b0, hi} + {1'b0, m};
        rem    = {hi, lo[31]};
        diff   = rem - {1'b0, m};
        ge     = ~diff[32];
        nxt_hi = hi;
        nxt_lo = lo;
        unique case (op)
            OP_MULT: begin
                if (lo[0]) {nxt_hi, nxt_lo} = {sum, lo[31:1]};
                else       {nxt_hi, nxt_lo} = {1'b0, hi, lo[31:1]};
            end
            OP_DIV: begin
                nxt_hi = ge ? diff[31:0] : rem[31:0];
                nxt_lo = {lo[30:0], ge};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
            m  <= '0;
        end else if (load) begin
            hi <= '0;
            lo <= lo_init;
            m  <= m_init;
        end else if (step) begin
            hi <= nxt_hi;
            lo <= nxt_lo;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register file with iterative mult/div sequencing,
// sign fix-up, mthi/mtlo writes and pipeline stall generation.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int ITER = hilo_muldiv_ctrl_pkg::ITER
)
(
    input logic               Clk,
    input logic               Rst,
    hilo_muldiv_ctrl_if.slave bus
);

    state_t      state;
    op_t         op;
    logic [4:0]  cnt;
    logic        busy;
    logic        done;
    logic        neg_p;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mt_hi_p;
    logic        mt_lo_p;
    logic [31:0] mt_data_q;

    logic        start;
    logic        is_div;
    logic        div0;
    logic        load;
    logic        stp;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] lo_init;
    logic [31:0] m_init;
    logic [31:0] s_hi;
    logic [31:0] s_lo;
    logic [63:0] res_p;
    logic [31:0] res_q;
    logic [31:0] res_r;

    assign start   = bus.StartMult | bus.StartDiv;
    assign is_div  = ~bus.StartMult & bus.StartDiv;
    assign div0    = is_div & (bus.OpB == '0);
    assign mag_a   = mag(bus.SignedOp, bus.OpA);
    assign mag_b   = mag(bus.SignedOp, bus.OpB);
    assign load    = (state == S_IDLE) & start;
    assign stp     = (state == S_RUN);
    // on divide-by-zero the raw dividend rides through lo to FIX
    assign lo_init = is_div ? (div0 ? bus.OpA : mag_a) : mag_b;
    assign m_init  = is_div ? mag_b : mag_a;

    muldiv_step u_step (
        .clk     (Clk),
        .rst     (Rst),
        .load    (load),
        .step    (stp),
        .op      (op),
        .lo_init (lo_init),
        .m_init  (m_init),
        .hi      (s_hi),
        .lo      (s_lo)
    );

    always_comb begin
        res_p = neg_p ? -{s_hi, s_lo} : {s_hi, s_lo};
        res_q = neg_q ? -s_lo : s_lo;
        res_r = neg_r ? -s_hi : s_hi;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_IDLE;
            op        <= OP_MULT;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            neg_p     <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            mt_hi_p   <= 1'b0;
            mt_lo_p   <= 1'b0;
            mt_data_q <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op        <= is_div ? OP_DIV : OP_MULT;
                        neg_p     <= bus.SignedOp & (bus.OpA[31] ^ bus.OpB[31]);
                        neg_q     <= bus.SignedOp & (bus.OpA[31] ^ bus.OpB[31]);
                        neg_r     <= bus.SignedOp & bus.OpA[31];
                        dz        <= div0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        mt_hi_p   <= bus.MtHi;
                        mt_lo_p   <= bus.MtLo;
                        mt_data_q <= bus.MtData;
                        state     <= div0 ? S_FIX : S_RUN;
                    end else begin
                        if (bus.MtHi) hi <= bus.MtData;
                        if (bus.MtLo) lo <= bus.MtData;
                    end
                end
                S_RUN: begin
                    if (mt_hi_p) hi <= mt_data_q;
                    if (mt_lo_p) lo <= mt_data_q;
                    mt_hi_p <= 1'b0;
                    mt_lo_p <= 1'b0;
                    cnt     <= cnt + 5'd1;
                    if (cnt == 5'(ITER - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (dz) begin
                        hi <= s_lo;
                        lo <= '1;
                    end else if (op == OP_MULT) begin
                        {hi, lo} <= res_p;
                    end else begin
                        hi <= res_r;
                        lo <= res_q;
                    end
                    mt_hi_p <= 1'b0;
                    mt_lo_p <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.HiOut = hi;
    assign bus.LoOut = lo;
    assign bus.Busy  = busy;
    assign bus.Done  = done;
    assign bus.Stall = busy & (bus.HiLoRead | bus.StartMult | bus.StartDiv
                               | bus.MtHi | bus.MtLo);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl with a result scoreboard.
module tb_hilo_muldiv_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q[$];

    hilo_muldiv_ctrl_if bus();

    hilo_muldiv_ctrl #(.ITER(32)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input bit mult, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] r;
        if (mult) begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                r  = sa * sb;
            end else begin
                r = {32'b0, a} * {32'b0, b};
            end
        end else if (b == 32'd0) begin
            r = {a, 32'hFFFFFFFF};
        end else if (sgn) begin
            r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        end else begin
            r = {a % b, a / b};
        end
        return r;
    endfunction

    task automatic issue(input bit mult, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(model(mult, sgn, a, b));
        bus.StartMult = mult;
        bus.StartDiv  = !mult;
        bus.SignedOp  = sgn;
        bus.OpA       = a;
        bus.OpB       = b;
        tick();
        bus.StartMult = 1'b0;
        bus.StartDiv  = 1'b0;
    endtask

    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (bus.Done !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.HiOut !== 32'd0 || bus.LoOut !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo: got %h_%h want 0_0", bus.HiOut, bus.LoOut);
        end
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b stall=%b want 0 0 0",
                     bus.Busy, bus.Done, bus.Stall);
        end
    endtask

    task automatic test_mult_signed();
        logic [63:0] e;
        issue(1'b1, 1'b1, 32'd7, -32'sd3);
        checks++;
        if (bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL mult_busy: got %b want 1", bus.Busy);
        end
        for (int k = 0; k < 33; k++) begin
            checks++;
            if (bus.HiOut !== 32'd0 || bus.LoOut !== 32'd0 || bus.Done !== 1'b0) begin
                errors++;
                $display("FAIL mult_stable k=%0d: got %h_%h done=%b want 0_0 done=0",
                         k, bus.HiOut, bus.LoOut, bus.Done);
            end
            tick();
        end
        checks++;
        if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_latency: done=%b busy=%b want 1 0", bus.Done, bus.Busy);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.HiOut, bus.LoOut} !== e) begin
            errors++;
            $display("FAIL mult_signed: got %h want %h", {bus.HiOut, bus.LoOut}, e);
        end
        checks++;
        if (bus.HiOut !== 32'hFFFFFFFF || bus.LoOut !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mult_7x-3: got %h_%h want ffffffff_ffffffeb",
                     bus.HiOut, bus.LoOut);
        end
        tick();
        checks++;
        if (bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %b want 0", bus.Done);
        end
    endtask

    task automatic test_mult_unsigned();
        int cyc;
        logic [63:0] e;
        issue(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, cyc);
        checks++;
        if (cyc != 33) begin
            errors++;
            $display("FAIL multu_latency: got %0d want 33", cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.HiOut, bus.LoOut} !== e || bus.HiOut !== 32'hFFFFFFFE
            || bus.LoOut !== 32'h00000001) begin
            errors++;
            $display("FAIL multu_max: got %h_%h want fffffffe_00000001",
                     bus.HiOut, bus.LoOut);
        end
    endtask

    task automatic test_div_signed();
        int cyc;
        logic [63:0] e;
        issue(1'b0, 1'b1, -32'sd7, 32'd2);
        wait_done(0, cyc);
        checks++;
        if (cyc != 33) begin
            errors++;
            $display("FAIL div_latency: got %0d want 33", cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.HiOut, bus.LoOut} !== e || bus.LoOut !== 32'hFFFFFFFD
            || bus.HiOut !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL div_-7/2: got %h_%h want ffffffff_fffffffd",
                     bus.HiOut, bus.LoOut);
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] e;
        issue(1'b0, 1'b0, 32'd100, 32'd0);
        checks++;
        if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL dz_busy: busy=%b done=%b want 1 0", bus.Busy, bus.Done);
        end
        tick();
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b1) begin
            errors++;
            $display("FAIL dz_done: busy=%b done=%b want 0 1", bus.Busy, bus.Done);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.HiOut, bus.LoOut} !== e || bus.HiOut !== 32'd100) begin
            errors++;
            $display("FAIL dz_result: got %h_%h want 00000064_ffffffff",
                     bus.HiOut, bus.LoOut);
        end
    endtask

    task automatic test_stall();
        int n;
        logic [63:0] e;
        issue(1'b1, 1'b0, 32'h00012345, 32'h00000100);
        repeat (4) tick();
        bus.HiLoRead = 1'b1;
        bus.OpA      = 32'd9;
        bus.OpB      = 32'd9;
        n = 0;
        while (n < 40 && bus.Busy === 1'b1) begin
            bus.StartMult = (n >= 3 && n < 10);
            #1;
            checks++;
            if (bus.Stall !== 1'b1) begin
                errors++;
                $display("FAIL stall_busy n=%0d: got %b want 1", n, bus.Stall);
            end
            tick();
            n++;
        end
        bus.StartMult = 1'b0;
        checks++;
        if (n != 29) begin
            errors++;
            $display("FAIL stall_len: got %0d want 29", n);
        end
        checks++;
        if (bus.Stall !== 1'b0 || bus.Done !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: stall=%b done=%b want 0 1", bus.Stall, bus.Done);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.HiOut, bus.LoOut} !== e) begin
            errors++;
            $display("FAIL stall_result: got %h want %h", {bus.HiOut, bus.LoOut}, e);
        end
        bus.HiLoRead = 1'b0;
        tick();
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_ignored: busy=%b want 0", bus.Busy);
        end
    endtask

    task automatic test_mt();
        int cyc;
        logic [63:0] e;
        bus.MtHi   = 1'b1;
        bus.MtData = 32'h11112222;
        tick();
        bus.MtHi   = 1'b0;
        checks++;
        if (bus.HiOut !== 32'h11112222) begin
            errors++;
            $display("FAIL mthi: got %h want 11112222", bus.HiOut);
        end
        bus.MtLo   = 1'b1;
        bus.MtData = 32'h33334444;
        tick();
        checks++;
        if (bus.LoOut !== 32'h33334444 || bus.HiOut !== 32'h11112222) begin
            errors++;
            $display("FAIL mtlo: got %h_%h want 11112222_33334444", bus.HiOut, bus.LoOut);
        end
        bus.MtData = 32'hAAAA5555;
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        bus.MtLo = 1'b0;
        checks++;
        if (bus.LoOut !== 32'h33334444) begin
            errors++;
            $display("FAIL mt_start_n: got %h want 33334444", bus.LoOut);
        end
        tick();
        checks++;
        if (bus.LoOut !== 32'hAAAA5555 || bus.HiOut !== 32'h11112222) begin
            errors++;
            $display("FAIL mt_start_n1: got %h_%h want 11112222_aaaa5555",
                     bus.HiOut, bus.LoOut);
        end
        wait_done(1, cyc);
        checks++;
        if (cyc != 33) begin
            errors++;
            $display("FAIL mt_op_latency: got %0d want 33", cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.HiOut, bus.LoOut} !== e) begin
            errors++;
            $display("FAIL mt_op_result: got %h want %h", {bus.HiOut, bus.LoOut}, e);
        end
    endtask

    task automatic test_random();
        int cyc;
        bit mult;
        bit sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e;
        for (int i = 0; i < 8; i++) begin
            mult = i[0];
            sgn  = i[1];
            a    = $urandom();
            b    = (i == 6) ? 32'd0 : ((i == 4) ? ($urandom() >> 20) : $urandom());
            if (!mult && sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            issue(mult, sgn, a, b);
            wait_done(0, cyc);
            checks++;
            if (cyc != ((!mult && b == 32'd0) ? 1 : 33)) begin
                errors++;
                $display("FAIL rand_latency i=%0d: got %0d", i, cyc);
            end
            e = exp_q.pop_front();
            checks++;
            if ({bus.HiOut, bus.LoOut} !== e) begin
                errors++;
                $display("FAIL rand_result i=%0d m=%0d s=%0d a=%h b=%h: got %h want %h",
                         i, mult, sgn, a, b, {bus.HiOut, bus.LoOut}, e);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        issue(1'b1, 1'b1, -32'sd5, 32'd123456);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (bus.HiOut !== 32'd0 || bus.LoOut !== 32'd0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got %h_%h busy=%b want 0_0 busy=0",
                     bus.HiOut, bus.LoOut, bus.Busy);
        end
        bus.MtHi   = 1'b1;
        bus.MtData = 32'h12345678;
        tick();
        bus.MtHi   = 1'b0;
        checks++;
        if (bus.HiOut !== 32'h12345678) begin
            errors++;
            $display("FAIL rst_mthi: got %h want 12345678", bus.HiOut);
        end
        dn = 0;
        repeat (40) begin
            if (bus.Done === 1'b1) dn++;
            tick();
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL rst_discard: got %0d done pulses want 0", dn);
        end
        rst           = 1'b1;
        bus.StartMult = 1'b1;
        bus.OpA       = 32'd3;
        bus.OpB       = 32'd3;
        bus.MtHi      = 1'b1;
        bus.MtData    = 32'hFFFF0000;
        tick();
        rst           = 1'b0;
        bus.StartMult = 1'b0;
        bus.MtHi      = 1'b0;
        checks++;
        if (bus.HiOut !== 32'd0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: hi=%h busy=%b want 0 0", bus.HiOut, bus.Busy);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.StartMult = 1'b0;
        bus.StartDiv  = 1'b0;
        bus.SignedOp  = 1'b0;
        bus.OpA       = '0;
        bus.OpB       = '0;
        bus.MtHi      = 1'b0;
        bus.MtLo      = 1'b0;
        bus.MtData    = '0;
        bus.HiLoRead  = 1'b0;
        test_reset();
        test_mult_signed();
        test_mult_unsigned();
        test_div_signed();
        test_div_zero();
        test_stall();
        test_mt();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
